// File: rtl/kyber_pkg.sv
// Shared constants, FSM encoding and addressing helper for the Kyber matrix store.
// The matrix is laid out as K_MAX x K_MAX slots of N coefficients, independent of the active k.
package kyber_pkg;

    localparam int K_MAX   = 4;
    localparam int N       = 256;
    localparam int COEF_W  = 16;

    localparam int K_IDX_W = $clog2(K_MAX);
    localparam int I_W     = $clog2(N);
    localparam int ADDR_W  = $clog2(K_MAX * K_MAX * N);

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t READ = 2'd2;

    function automatic logic [ADDR_W-1:0] poly_base(input logic [K_IDX_W-1:0] row,
                                                    input logic [K_IDX_W-1:0] col);
        return ADDR_W'((int'(row) * K_MAX + int'(col)) * N);
    endfunction

endpackage

// File: rtl/kyber_coef_ram.sv
// Simple dual-port coefficient RAM: one write port, one registered read port, no reset.
module kyber_coef_ram #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/kyber_matrix_store.sv
// Kyber public-matrix store: row-major stream load, per-polynomial read with optional
// transposed addressing and a 2-entry skid buffer behind the registered RAM read.
module kyber_matrix_store #(
    parameter int K_MAX  = kyber_pkg::K_MAX,
    parameter int N      = kyber_pkg::N,
    parameter int COEF_W = kyber_pkg::COEF_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               k_level,
    input  logic                     load_start,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [COEF_W-1:0]        wr_data,
    output logic                     load_done,
    input  logic                     rd_start,
    input  logic [$clog2(K_MAX)-1:0] rd_row,
    input  logic [$clog2(K_MAX)-1:0] rd_col,
    input  logic                     rd_transpose,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [COEF_W-1:0]        rd_data,
    output logic                     rd_last,
    output logic                     busy,
    output logic                     loaded,
    output logic                     err
);

    import kyber_pkg::*;

    localparam int KW = $clog2(K_MAX);
    localparam int IW = $clog2(N);
    localparam int AW = $clog2(K_MAX * K_MAX * N);

    function automatic logic [AW-1:0] addr_of(input logic [KW-1:0] row,
                                              input logic [KW-1:0] col,
                                              input logic [IW-1:0] idx);
        return AW'((int'(row) * K_MAX + int'(col)) * N + int'(idx));
    endfunction

    state_t              state_r;
    logic [2:0]          k_r;
    logic [KW-1:0]       wr_row_r, wr_col_r;
    logic [IW-1:0]       wr_i_r;
    logic [KW-1:0]       rd_row_r, rd_col_r;
    logic [IW-1:0]       rd_i_r;
    logic                issue_done_r;
    logic                inflight_r, inflight_last_r;
    logic [COEF_W-1:0]   skid_data_r [2];
    logic                skid_last_r [2];
    logic                wptr_r, rptr_r;
    logic [1:0]          cnt_r;
    logic                loaded_r, load_done_r, err_r;

    logic                k_ok_s, rd_ok_s, wr_fire_s, wr_last_s;
    logic                pop_s, pop_last_s, issue_s;
    logic [1:0]          occ_s;
    logic [COEF_W-1:0]   ram_q_s;

    assign k_ok_s     = (k_level >= 3'd2) && (k_level <= 3'(K_MAX));
    assign rd_ok_s    = loaded_r && (3'(rd_row) < k_r) && (3'(rd_col) < k_r);
    assign wr_fire_s  = (state_r == LOAD) && wr_valid;
    assign wr_last_s  = wr_fire_s && (wr_i_r == IW'(N - 1))
                        && (3'(wr_col_r) == k_r - 3'd1) && (3'(wr_row_r) == k_r - 3'd1);
    assign pop_s      = (state_r == READ) && (cnt_r != 2'd0) && rd_ready;
    assign pop_last_s = pop_s && skid_last_r[rptr_r];
    // Entries held plus the one in flight must leave room for the next RAM read.
    assign occ_s      = cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
    assign issue_s    = (state_r == READ) && !issue_done_r && (occ_s < 2'd2);

    kyber_coef_ram #(
        .DEPTH (K_MAX * K_MAX * N),
        .WIDTH (COEF_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire_s),
        .waddr (addr_of(wr_row_r, wr_col_r, wr_i_r)),
        .wdata (wr_data),
        .re    (issue_s),
        .raddr (addr_of(rd_row_r, rd_col_r, rd_i_r)),
        .rdata (ram_q_s)
    );

    // Control FSM, load/read counters and skid buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            k_r             <= 3'd0;
            wr_row_r        <= {KW{1'b0}};
            wr_col_r        <= {KW{1'b0}};
            wr_i_r          <= {IW{1'b0}};
            rd_row_r        <= {KW{1'b0}};
            rd_col_r        <= {KW{1'b0}};
            rd_i_r          <= {IW{1'b0}};
            issue_done_r    <= 1'b0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            skid_data_r[0]  <= {COEF_W{1'b0}};
            skid_data_r[1]  <= {COEF_W{1'b0}};
            skid_last_r[0]  <= 1'b0;
            skid_last_r[1]  <= 1'b0;
            wptr_r          <= 1'b0;
            rptr_r          <= 1'b0;
            cnt_r           <= 2'd0;
            loaded_r        <= 1'b0;
            load_done_r     <= 1'b0;
            err_r           <= 1'b0;
        end else begin
            load_done_r <= 1'b0;
            err_r       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_start) begin
                        if (k_ok_s) begin
                            state_r  <= LOAD;
                            k_r      <= k_level;
                            loaded_r <= 1'b0;
                            wr_row_r <= {KW{1'b0}};
                            wr_col_r <= {KW{1'b0}};
                            wr_i_r   <= {IW{1'b0}};
                        end else begin
                            err_r <= 1'b1;
                        end
                    end else if (rd_start) begin
                        if (rd_ok_s) begin
                            state_r      <= READ;
                            rd_row_r     <= rd_transpose ? rd_col : rd_row;
                            rd_col_r     <= rd_transpose ? rd_row : rd_col;
                            rd_i_r       <= {IW{1'b0}};
                            issue_done_r <= 1'b0;
                            inflight_r   <= 1'b0;
                            cnt_r        <= 2'd0;
                            wptr_r       <= 1'b0;
                            rptr_r       <= 1'b0;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (wr_last_s) begin
                        state_r     <= IDLE;
                        loaded_r    <= 1'b1;
                        load_done_r <= 1'b1;
                    end else if (wr_fire_s) begin
                        if (wr_i_r == IW'(N - 1)) begin
                            wr_i_r <= {IW{1'b0}};
                            if (3'(wr_col_r) == k_r - 3'd1) begin
                                wr_col_r <= {KW{1'b0}};
                                wr_row_r <= wr_row_r + KW'(1);
                            end else begin
                                wr_col_r <= wr_col_r + KW'(1);
                            end
                        end else begin
                            wr_i_r <= wr_i_r + IW'(1);
                        end
                    end
                end
                READ: begin
                    if (issue_s) begin
                        rd_i_r <= rd_i_r + IW'(1);
                        if (rd_i_r == IW'(N - 1)) begin
                            issue_done_r <= 1'b1;
                        end
                    end
                    inflight_r      <= issue_s;
                    inflight_last_r <= issue_s && (rd_i_r == IW'(N - 1));
                    if (inflight_r) begin
                        skid_data_r[wptr_r] <= ram_q_s;
                        skid_last_r[wptr_r] <= inflight_last_r;
                        wptr_r              <= ~wptr_r;
                    end
                    if (pop_s) begin
                        rptr_r <= ~rptr_r;
                    end
                    cnt_r <= cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
                    if (pop_last_s) begin
                        state_r    <= IDLE;
                        cnt_r      <= 2'd0;
                        wptr_r     <= 1'b0;
                        rptr_r     <= 1'b0;
                        inflight_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign wr_ready  = (state_r == LOAD);
    assign busy      = (state_r != IDLE);
    assign loaded    = loaded_r;
    assign load_done = load_done_r;
    assign err       = err_r;
    assign rd_valid  = (cnt_r != 2'd0);
    assign rd_data   = skid_data_r[rptr_r];
    assign rd_last   = rd_valid && skid_last_r[rptr_r];

endmodule

// File: tb/tb_kyber_matrix_store.sv
// Directed bench for kyber_matrix_store: loads with data = beat index, reads polynomials
// under several rd_ready patterns, and exercises the rejection and reset corner cases.
module tb_kyber_matrix_store;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  k_level;
    logic        load_start;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        load_done;
    logic        rd_start;
    logic [1:0]  rd_row;
    logic [1:0]  rd_col;
    logic        rd_transpose;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        busy;
    logic        loaded;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kyber_matrix_store dut (
        .clk          (clk),
        .rst          (rst),
        .k_level      (k_level),
        .load_start   (load_start),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .load_done    (load_done),
        .rd_start     (rd_start),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_transpose (rd_transpose),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .busy         (busy),
        .loaded       (loaded),
        .err          (err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [2:0] k);
        int total;
        total = int'(k) * int'(k) * 256;
        load_start = 1'b1;
        k_level    = k;
        step;
        load_start = 1'b0;
        check1("load_busy", busy, 1'b1);
        check1("load_wr_ready", wr_ready, 1'b1);
        check1("load_loaded_cleared", loaded, 1'b0);
        for (int b = 0; b < total; b++) begin
            if (b % 97 == 5) begin
                wr_valid = 1'b0;
                step;
            end
            wr_valid = 1'b1;
            wr_data  = 16'(b);
            if (b == 300) begin
                load_start = 1'b1;
                k_level    = 3'd5;
            end
            step;
            load_start = 1'b0;
            k_level    = k;
            if (b == 300) begin
                check1("load_start_ignored_err", err, 1'b0);
                check1("load_start_ignored_busy", busy, 1'b1);
            end
            if (b == total - 2) begin
                check1("load_done_early", load_done, 1'b0);
            end
        end
        wr_valid = 1'b0;
        check1("load_done_pulse", load_done, 1'b1);
        check1("load_loaded", loaded, 1'b1);
        check1("load_end_busy", busy, 1'b0);
        check1("load_end_wr_ready", wr_ready, 1'b0);
        step;
        check1("load_done_one_cycle", load_done, 1'b0);
    endtask

    // mode 0: rd_ready always 1; mode 1: repeating 1,0,0,1; mode 2: random.
    task automatic do_read(input logic [1:0] row, input logic [1:0] col, input logic t,
                           input int base, input int mode);
        int n;
        int cyc;
        int first;
        logic [3:0] pat;
        pat          = 4'b1001;
        rd_row       = row;
        rd_col       = col;
        rd_transpose = t;
        rd_start     = 1'b1;
        rd_ready     = 1'b1;
        step;
        rd_start = 1'b0;
        check1("rd_busy", busy, 1'b1);
        n     = 0;
        cyc   = 0;
        first = -1;
        while (n < 256 && cyc < 4000) begin
            case (mode)
                1:       rd_ready = pat[cyc % 4];
                2:       rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = 1'b1;
            endcase
            if (rd_valid && first < 0) begin
                first = cyc;
            end
            if (rd_valid) begin
                check32("rd_data", 32'(rd_data), base + n);
                check1("rd_last", rd_last, (n == 255));
                if (rd_ready) begin
                    n++;
                end
            end
            step;
            cyc++;
        end
        rd_ready = 1'b0;
        check32("rd_count", n, 256);
        if (mode == 0) begin
            check32("rd_latency", first, 2);
            check32("rd_throughput", cyc, 258);
        end
        check1("rd_end_busy", busy, 1'b0);
        check1("rd_end_valid", rd_valid, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        k_level      = 3'd0;
        load_start   = 1'b0;
        wr_valid     = 1'b0;
        wr_data      = 16'd0;
        rd_start     = 1'b0;
        rd_row       = 2'd0;
        rd_col       = 2'd0;
        rd_transpose = 1'b0;
        rd_ready     = 1'b0;
        step;
        step;
        check1("rst_busy", busy, 1'b0);
        check1("rst_loaded", loaded, 1'b0);
        check1("rst_wr_ready", wr_ready, 1'b0);
        check1("rst_rd_valid", rd_valid, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_load_done", load_done, 1'b0);
        check1("rst_rd_last", rd_last, 1'b0);
        check32("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        step;

        // Read before any load.
        rd_start = 1'b1;
        step;
        rd_start = 1'b0;
        check1("unloaded_rd_err", err, 1'b1);
        check1("unloaded_rd_busy", busy, 1'b0);
        step;
        check1("err_one_cycle", err, 1'b0);

        // Unsupported security level.
        load_start = 1'b1;
        k_level    = 3'd5;
        step;
        load_start = 1'b0;
        check1("bad_k_err", err, 1'b1);
        check1("bad_k_busy", busy, 1'b0);
        check1("bad_k_wr_ready", wr_ready, 1'b0);
        step;

        // k=2, A[1][0] -> 512..767.
        do_load(3'd2);
        do_read(2'd1, 2'd0, 1'b0, 512, 0);

        // k=3, transposed rd(0,2) -> A[2][0] -> 1536..1791; then out-of-range row.
        do_load(3'd3);
        do_read(2'd0, 2'd2, 1'b1, 1536, 0);
        rd_row       = 2'd3;
        rd_col       = 2'd0;
        rd_transpose = 1'b0;
        rd_start     = 1'b1;
        step;
        rd_start = 1'b0;
        check1("row_range_err", err, 1'b1);
        check1("row_range_busy", busy, 1'b0);
        step;

        // k=4, backpressured reads: A[1][1] -> 1280..1535, A^T(0,3) -> A[3][0] -> 3072..3327.
        do_load(3'd4);
        do_read(2'd1, 2'd1, 1'b0, 1280, 1);
        do_read(2'd0, 2'd3, 1'b1, 3072, 2);

        // Simultaneous load_start and rd_start while loaded: load wins silently.
        load_start = 1'b1;
        k_level    = 3'd2;
        rd_start   = 1'b1;
        rd_row     = 2'd0;
        rd_col     = 2'd0;
        rd_ready   = 1'b1;
        step;
        load_start = 1'b0;
        rd_start   = 1'b0;
        check1("both_busy", busy, 1'b1);
        check1("both_wr_ready", wr_ready, 1'b1);
        check1("both_err", err, 1'b0);
        check1("both_loaded", loaded, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step;
            check1("both_no_rd_valid", rd_valid, 1'b0);
            check1("both_no_err", err, 1'b0);
        end

        // Reset at beat 100 of that load.
        for (int b = 0; b < 100; b++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(b);
            step;
        end
        rst = 1'b1;
        step;
        rst      = 1'b0;
        wr_valid = 1'b0;
        check1("mid_rst_loaded", loaded, 1'b0);
        check1("mid_rst_wr_ready", wr_ready, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        rd_start = 1'b1;
        step;
        rd_start = 1'b0;
        check1("post_rst_rd_err", err, 1'b1);
        check1("post_rst_rd_busy", busy, 1'b0);
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
